// File: rtl/icache_stream_prefetcher.sv
// Opcode constants shared with the I-cache request arbiter.
package toy_pack;
  localparam int ICACHE_REQ_OPCODE_WIDTH = 4;
  localparam logic [ICACHE_REQ_OPCODE_WIDTH-1:0] PREFETCH_OPCODE = 4'h6;
endpackage

// Purpose: issue sequential next-line I-cache prefetches (miss+1 .. miss+degree) per demand miss.
// Latency: first request valid one cycle after the accepted miss, then one line per handshake.
// Backpressure: registered valid/ready; vld and addr hold while rdy=0 (only flush/rst drop them).
module icache_stream_prefetcher #(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int OPCODE_WIDTH = toy_pack::ICACHE_REQ_OPCODE_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] PF_OPCODE = toy_pack::PREFETCH_OPCODE,
  parameter int MAX_DEGREE = 4,
  parameter int PAGE_LINE_BITS = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_enable,
  input  logic [$clog2(MAX_DEGREE+1)-1:0] cfg_degree,
  input  logic                          flush,
  input  logic                          miss_vld,
  input  logic [LINE_ADDR_WIDTH-1:0]    miss_addr,
  output logic                          prefetch_req_vld,
  input  logic                          prefetch_req_rdy,
  output logic [OPCODE_WIDTH-1:0]       prefetch_req_opcode,
  output logic [LINE_ADDR_WIDTH-1:0]    prefetch_req_addr,
  output logic [CNT_WIDTH-1:0]          pf_issue_cnt
);

  localparam int AW = LINE_ADDR_WIDTH;
  localparam int DW = $clog2(MAX_DEGREE+1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   base, base_nxt;
  logic [AW-1:0]   pend, pend_nxt;
  logic            pend_vld, pend_vld_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            vld_q, vld_nxt;
  logic [DW-1:0]   off, off_nxt;
  logic [DW-1:0]   dact, dact_nxt;
  logic [CNT_WIDTH-1:0] cnt;

  logic [DW-1:0]   deg_eff;
  logic            hs;
  logic            miss_dup;
  logic            miss_acc;
  logic [AW-1:0]   miss_next;
  logic [AW-1:0]   line_next;
  logic [AW-1:0]   promo_base;
  logic [AW-1:0]   promo_next;

  // True when two line addresses sit in the same page.
  function automatic logic same_page(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return a[AW-1:PAGE_LINE_BITS] == b[AW-1:PAGE_LINE_BITS];
  endfunction

  assign deg_eff    = (cfg_degree > DW'(MAX_DEGREE)) ? DW'(MAX_DEGREE) : cfg_degree;
  assign hs         = vld_q & prefetch_req_rdy;
  // Unsigned distance from base catches the whole [base, base+D_active] window.
  assign miss_dup   = (state == ACTIVE) &&
                      ((miss_addr - base) <= {{(AW-DW){1'b0}}, dact});
  assign miss_acc   = miss_vld && cfg_enable && (deg_eff != '0) && !miss_dup && !flush;
  assign miss_next  = miss_addr + AW'(1);
  assign line_next  = base + {{(AW-DW){1'b0}}, off} + AW'(1);
  // A miss arriving with a handshake counts as the freshest pending entry.
  assign promo_base = miss_acc ? miss_addr : pend;
  assign promo_next = promo_base + AW'(1);

  // Next-state and next-request selection; every target holds by default.
  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    addr_nxt     = addr_q;
    vld_nxt      = vld_q;
    off_nxt      = off;
    dact_nxt     = dact;
    if (flush) begin
      state_nxt    = IDLE;
      vld_nxt      = 1'b0;
      pend_vld_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_acc && same_page(miss_addr, miss_next)) begin
            state_nxt = ACTIVE;
            vld_nxt   = 1'b1;
            addr_nxt  = miss_next;
            base_nxt  = miss_addr;
            off_nxt   = DW'(1);
            dact_nxt  = deg_eff;
          end
        end
        ACTIVE: begin
          if (hs) begin
            if (miss_acc || pend_vld) begin
              pend_vld_nxt = 1'b0;
              if ((deg_eff != '0) && same_page(promo_base, promo_next)) begin
                vld_nxt  = 1'b1;
                addr_nxt = promo_next;
                base_nxt = promo_base;
                off_nxt  = DW'(1);
                dact_nxt = deg_eff;
              end else begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
              end
            end else if ((off == dact) || !same_page(base, line_next)) begin
              state_nxt = IDLE;
              vld_nxt   = 1'b0;
            end else begin
              off_nxt  = off + DW'(1);
              addr_nxt = line_next;
            end
          end else if (miss_acc) begin
            pend_vld_nxt = 1'b1;
            pend_nxt     = miss_addr;
          end
        end
        default: begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State, stream registers and the issue counter (handshakes count even during flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      off      <= '0;
      dact     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      addr_q   <= addr_nxt;
      vld_q    <= vld_nxt;
      off      <= off_nxt;
      dact     <= dact_nxt;
      cnt      <= cnt + CNT_WIDTH'(hs);
    end
  end

  assign prefetch_req_vld    = vld_q;
  assign prefetch_req_addr   = addr_q;
  assign prefetch_req_opcode = PF_OPCODE;
  assign pf_issue_cnt        = cnt;

endmodule

// File: tb/tb_icache_stream_prefetcher.sv
// Purpose: directed checks of the stream prefetcher (sequence, backpressure, page, supersede, flush, config, wrap).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: prefetch_req_rdy driven directly by the directed steps.
module tb_icache_stream_prefetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [2:0]  cfg_degree;
  logic        flush;
  logic        miss_vld;
  logic [25:0] miss_addr;
  logic        prefetch_req_vld;
  logic        prefetch_req_rdy;
  logic [3:0]  prefetch_req_opcode;
  logic [25:0] prefetch_req_addr;
  logic [15:0] pf_issue_cnt;

  int total = 0;
  int bad = 0;

  icache_stream_prefetcher dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_enable          (cfg_enable),
    .cfg_degree          (cfg_degree),
    .flush               (flush),
    .miss_vld            (miss_vld),
    .miss_addr           (miss_addr),
    .prefetch_req_vld    (prefetch_req_vld),
    .prefetch_req_rdy    (prefetch_req_rdy),
    .prefetch_req_opcode (prefetch_req_opcode),
    .prefetch_req_addr   (prefetch_req_addr),
    .pf_issue_cnt        (pf_issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic [25:0] exp_addr);
    chk({tag, "_vld"}, 32'(prefetch_req_vld), 32'h1);
    chk({tag, "_addr"}, 32'(prefetch_req_addr), 32'(exp_addr));
  endtask

  task automatic miss(input logic [25:0] a);
    miss_vld  = 1'b1;
    miss_addr = a;
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b1; cfg_degree = 3'd3; flush = 1'b0;
    miss_vld = 1'b0; miss_addr = '0; prefetch_req_rdy = 1'b1;
    tick(); tick();
    chk("rst_vld", 32'(prefetch_req_vld), 32'h0);
    chk("rst_addr", 32'(prefetch_req_addr), 32'h0);
    chk("rst_cnt", 32'(pf_issue_cnt), 32'h0);
    chk("opcode", 32'(prefetch_req_opcode), 32'h6);
    rst = 1'b0;
    tick();

    // Sequential degree 3
    miss(26'h100); tick(); miss_vld = 1'b0;
    chk_req("seq1", 26'h101);
    tick(); chk_req("seq2", 26'h102);
    tick(); chk_req("seq3", 26'h103);
    tick(); chk("seq_end_vld", 32'(prefetch_req_vld), 32'h0);
    chk("seq_cnt", 32'(pf_issue_cnt), 32'd3);

    // Backpressure: held for five cycles
    prefetch_req_rdy = 1'b0;
    miss(26'h100); tick(); miss_vld = 1'b0;
    chk_req("bp_hold0", 26'h101);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_req("bp_hold", 26'h101);
    end
    prefetch_req_rdy = 1'b1;
    tick(); chk_req("bp_next", 26'h102);
    tick(); chk_req("bp_last", 26'h103);
    tick(); chk("bp_end_vld", 32'(prefetch_req_vld), 32'h0);
    chk("bp_cnt", 32'(pf_issue_cnt), 32'd6);

    // Page boundary
    cfg_degree = 3'd4;
    miss(26'h13E); tick(); miss_vld = 1'b0;
    chk_req("pg_13f", 26'h13F);
    tick(); chk("pg_stop_vld", 32'(prefetch_req_vld), 32'h0);
    miss(26'h13F); tick(); miss_vld = 1'b0;
    chk("pg_drop_vld", 32'(prefetch_req_vld), 32'h0);
    miss(26'h3FFFFFF); tick(); miss_vld = 1'b0;
    chk("pg_wrap_vld", 32'(prefetch_req_vld), 32'h0);
    chk("pg_cnt", 32'(pf_issue_cnt), 32'd7);

    // Duplicate filtered, newer miss supersedes
    prefetch_req_rdy = 1'b0;
    miss(26'h100); tick();
    miss(26'h102); tick();
    miss(26'h200); tick(); miss_vld = 1'b0;
    chk_req("dup_hold", 26'h101);
    prefetch_req_rdy = 1'b1;
    tick(); chk_req("sup_201", 26'h201);
    chk("sup_cnt", 32'(pf_issue_cnt), 32'd8);
    tick(); chk_req("sup_202", 26'h202);
    tick(); chk_req("sup_203", 26'h203);
    tick(); chk_req("sup_204", 26'h204);
    tick(); chk("sup_end_vld", 32'(prefetch_req_vld), 32'h0);
    tick(); chk("dup_none_vld", 32'(prefetch_req_vld), 32'h0);
    chk("sup_end_cnt", 32'(pf_issue_cnt), 32'd12);

    // Flush while stalled on 0x102 with a pending miss
    miss(26'h100); tick(); miss_vld = 1'b0;
    tick(); chk_req("fl_102", 26'h102);
    prefetch_req_rdy = 1'b0;
    miss(26'h300); tick(); miss_vld = 1'b0;
    chk_req("fl_hold", 26'h102);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_vld", 32'(prefetch_req_vld), 32'h0);
    prefetch_req_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fl_quiet_vld", 32'(prefetch_req_vld), 32'h0);
    end
    chk("fl_cnt", 32'(pf_issue_cnt), 32'd13);

    // Reset mid-stream
    miss(26'h100); tick(); miss_vld = 1'b0;
    tick(); chk_req("rs_102", 26'h102);
    chk("rs_pre_cnt", 32'(pf_issue_cnt), 32'd14);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_vld", 32'(prefetch_req_vld), 32'h0);
    chk("rs_addr", 32'(prefetch_req_addr), 32'h0);
    chk("rs_cnt", 32'(pf_issue_cnt), 32'h0);
    tick(); chk("rs_quiet_vld", 32'(prefetch_req_vld), 32'h0);

    // Config: degree 0, enable 0, clamp 7 -> 4
    cfg_degree = 3'd0;
    miss(26'h400); tick(); miss_vld = 1'b0;
    chk("deg0_vld", 32'(prefetch_req_vld), 32'h0);
    cfg_degree = 3'd4; cfg_enable = 1'b0;
    miss(26'h400); tick(); miss_vld = 1'b0;
    chk("en0_vld", 32'(prefetch_req_vld), 32'h0);
    cfg_enable = 1'b1; cfg_degree = 3'd7;
    miss(26'h400); tick(); miss_vld = 1'b0;
    chk_req("clamp1", 26'h401);
    tick(); chk_req("clamp2", 26'h402);
    tick(); chk_req("clamp3", 26'h403);
    tick(); chk_req("clamp4", 26'h404);
    tick(); chk("clamp_end_vld", 32'(prefetch_req_vld), 32'h0);
    chk("clamp_cnt", 32'(pf_issue_cnt), 32'd4);

    // Disable mid-stream: stream completes, new miss ignored
    cfg_degree = 3'd2;
    miss(26'h500); tick();
    cfg_enable = 1'b0;
    miss(26'h600); tick(); miss_vld = 1'b0;
    chk_req("dis_502", 26'h502);
    tick(); chk("dis_end_vld", 32'(prefetch_req_vld), 32'h0);
    tick(); chk("dis_quiet_vld", 32'(prefetch_req_vld), 32'h0);
    chk("dis_cnt", 32'(pf_issue_cnt), 32'd6);
    cfg_enable = 1'b1;

    // Counter wrap: a promoted miss every cycle keeps one handshake per edge
    cfg_degree = 3'd4;
    miss(26'h1000); tick();
    chk_req("wr_start", 26'h1001);
    for (int i = 0; i < 65529; i++) begin
      miss(((i % 2) == 0) ? 26'h2000 : 26'h1000);
      tick();
    end
    miss_vld = 1'b0;
    chk("wr_cnt_ffff", 32'(pf_issue_cnt), 32'hFFFF);
    chk_req("wr_addr", 26'h2001);
    tick();
    chk("wr_cnt_0", 32'(pf_issue_cnt), 32'h0);
    chk_req("wr_addr2", 26'h2002);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("wr_flush_vld", 32'(prefetch_req_vld), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
